// File: rtl/mem_store_unit_pkg.sv
// Shared definitions for the store unit: size and error encodings, FSM states, word geometry.
// WORD_LEN is taken from the project config when already defined, otherwise it defaults to 32.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

package mem_store_unit_pkg;

  localparam int BYTES_PER_WORD = `WORD_LEN / 8;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_SIZE     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

endpackage

// File: rtl/store_lane_packer.sv
// Combinational lane packer: replicates the narrowed operand across byte lanes,
// builds byte enables and flags addresses that are misaligned for the access size.
module store_lane_packer
  import mem_store_unit_pkg::*;
(
  input  logic [1:0]           size,
  input  logic [1:0]           off,
  input  logic [`WORD_LEN-1:0] data,
  output logic [`WORD_LEN-1:0] wdata,
  output logic [3:0]           be,
  output logic                 misaligned
);

  always_comb begin
    wdata      = data;
    be         = 4'b1111;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        wdata = {BYTES_PER_WORD{data[7:0]}};
        be    = 4'b0001 << off;
      end
      SZ_HALF: begin
        // off[0] is ignored for the enables, which silently aligns odd halves
        wdata      = {(BYTES_PER_WORD / 2){data[15:0]}};
        be         = off[1] ? 4'b1100 : 4'b0011;
        misaligned = off[0];
      end
      SZ_WORD: begin
        misaligned = (off != 2'b00);
      end
      default: begin
        be = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_store_unit.sv
// Store unit: accepts SB/SH/SW, runs a req/ack write to data memory with a timeout.
// Define STORE_MISALIGN_TRAP_EN to trap misaligned half/word stores instead of aligning them.
module mem_store_unit
  import mem_store_unit_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 st_valid,
  output logic                 st_ready,
  input  logic [1:0]           st_size,
  input  logic [ADDR_W-1:0]    st_addr,
  input  logic [`WORD_LEN-1:0] st_data,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [`WORD_LEN-1:0] mem_wdata,
  output logic [3:0]           mem_be,
  input  logic                 mem_ack,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  // Handshake: a store is taken on a rising edge where st_valid && st_ready; st_ready is
  // high only in IDLE, so a new store is never accepted while one is in flight.

`ifdef STORE_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam int TW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [TW-1:0] TMAX = TW'(WAIT_MAX - 1);

  state_t               state, state_next;
  logic [TW-1:0]        timer;
  logic [`WORD_LEN-1:0] pk_wdata;
  logic [3:0]           pk_be;
  logic                 pk_misaligned;
  logic                 bad_size;
  logic                 misalign_trap;
  logic                 reject;
  logic                 timer_done;

  store_lane_packer u_packer (
    .size       (st_size),
    .off        (st_addr[1:0]),
    .data       (st_data),
    .wdata      (pk_wdata),
    .be         (pk_be),
    .misaligned (pk_misaligned)
  );

  assign bad_size      = (st_size == SZ_ILLEGAL);
  assign misalign_trap = TRAP_EN & pk_misaligned;
  assign reject        = bad_size | misalign_trap;
  assign timer_done    = (timer == TMAX);

  assign st_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign mem_req   = (state == ST_REQ);
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (st_valid) state_next = reject ? ST_ERR : ST_REQ;
      ST_REQ:  if (mem_ack || timer_done) state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (st_valid) begin
            mem_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= pk_wdata;
            if (reject) begin
              err      <= 1'b1;
              err_code <= bad_size ? ERR_SIZE : ERR_MISALIGN;
            end else begin
              mem_be <= pk_be;
            end
          end
        end
        ST_REQ: begin
          // ack is checked first so it wins over a timeout in the same cycle
          if (mem_ack) begin
            done   <= 1'b1;
            mem_be <= 4'b0000;
            timer  <= '0;
          end else if (timer_done) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            mem_be   <= 4'b0000;
            timer    <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_store_unit.sv
// Bench for mem_store_unit: directed and random stores, reference model feeding a
// scoreboard queue, independent monitor comparing each done/err response.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module tb_mem_store_unit;

  localparam int ADDR_W   = 32;
  localparam int WAIT_MAX = 15;
  localparam int EW       = 80;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;
  logic [1:0]  dbg_state;

  mem_store_unit #(.ADDR_W(ADDR_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_size   (st_size),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int             checks = 0;
  int             passes = 0;
  logic [EW-1:0]  exp_q[$];
  int             ack_delay = 0;
  int             rsp_cnt = 0;
  logic [1:0]     last_code = 2'b00;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected response: {is_err, err_code, st_ready, req_cycles[7:0], addr, wdata, be}
  function automatic logic [EW-1:0] model(input logic [1:0] size, input logic [31:0] addr,
                                          input logic [31:0] d, input int dly);
    logic        is_err = 1'b0;
    logic [1:0]  code   = last_code;
    logic        rdy    = 1'b1;
    logic [7:0]  cyc    = 8'd0;
    logic [31:0] a      = 32'd0;
    logic [31:0] w      = 32'd0;
    logic [3:0]  b      = 4'd0;
    int          off    = int'(addr[1:0]);
    if (size == 2'd3) begin
      is_err = 1'b1; code = 2'd3; rdy = 1'b0;
    end
`ifdef STORE_MISALIGN_TRAP_EN
    else if ((size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && off != 0)) begin
      is_err = 1'b1; code = 2'd1; rdy = 1'b0;
    end
`endif
    else begin
      a = addr - 32'(off);
      case (size)
        2'd0: begin w = {24'h0, d[7:0]} * 32'h01010101; b = 4'(1 << off); end
        2'd1: begin w = {16'h0, d[15:0]} * 32'h00010001; b = (off >= 2) ? 4'hC : 4'h3; end
        default: begin w = d; b = 4'hF; end
      endcase
      if (dly < WAIT_MAX) cyc = 8'(dly + 1);
      else begin cyc = 8'(WAIT_MAX); is_err = 1'b1; code = 2'd2; end
    end
    return {is_err, code, rdy, cyc, a, w, b};
  endfunction

  // memory responder: acks after ack_delay wait cycles, random noise outside REQ
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      mem_ack = (rsp_cnt == ack_delay);
      rsp_cnt++;
    end else begin
      rsp_cnt = 0;
      mem_ack = 1'($urandom_range(0, 1));
    end
  end

  // driver
  task automatic store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data,
                       input int dly, input bit push);
    int n = 0;
    logic [EW-1:0] e;
    st_size  = size;
    st_addr  = addr;
    st_data  = data;
    st_valid = 1'b1;
    while (!st_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!st_ready) begin
      checks++;
      $display("FAIL accept_timeout: st_ready stayed %b, required 1", st_ready);
      st_valid = 1'b0;
      return;
    end
    ack_delay = dly;
    if (push) begin
      e = model(size, addr, data, dly);
      exp_q.push_back(e);
      if (e[79]) last_code = e[78:77];
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  // monitor / scoreboard
  bit          tracking = 1'b0;
  int          lat = 0;
  int          rq = 0;
  logic [67:0] cap = '0;

  always @(negedge clk) begin
    logic [EW-1:0] obs, e;
    if (!rst_n) begin
      tracking = 1'b0; lat = 0; rq = 0; cap = '0;
    end else begin
      if (tracking) lat++;
      if (mem_req) begin
        check("ready_in_req", 80'(st_ready), 80'(1'b0));
        check("addr_aligned", 80'(mem_addr[1:0]), 80'(2'b00));
        if (rq == 0) cap = {mem_addr, mem_wdata, mem_be};
        else check("req_stable", 80'({mem_addr, mem_wdata, mem_be}), 80'(cap));
        rq++;
      end else begin
        check("be_idle", 80'(mem_be), 80'(4'b0000));
      end
      if (done || err) begin
        obs = {err, err_code, st_ready, 8'(rq), cap};
        if (done && err) begin
          checks++;
          $display("FAIL done_err_both: done=%b err=%b, required one", done, err);
        end
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_resp: done=%b err=%b, required none", done, err);
        end else begin
          e = exp_q.pop_front();
          check("response", obs, e);
          check("latency", 80'(lat), 80'(int'(e[75:68]) + 1));
        end
        tracking = 1'b0;
      end
      if (st_valid && st_ready) begin
        tracking = 1'b1; lat = 0; rq = 0; cap = '0;
      end
    end
  end

  initial begin
    int n;
    int r;
    logic [1:0] sz;
    st_valid = 1'b0;
    st_size  = 2'b00;
    st_addr  = 32'h0;
    st_data  = 32'h0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state",
          80'({mem_req, mem_addr, mem_wdata, mem_be, done, err, err_code, busy, st_ready, dbg_state}),
          80'({1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00}));
    rst_n = 1'b1;
    @(posedge clk); #1;

    store(2'd0, 32'h103, 32'hDEADBEEF, 0, 1'b1);
    store(2'd1, 32'h202, 32'h0000CAFE, 3, 1'b1);
    store(2'd2, 32'h301, 32'h11223344, 0, 1'b1);
    store(2'd2, 32'h400, 32'hA5A5A5A5, 99, 1'b1);
    store(2'd3, 32'h500, 32'h55667788, 0, 1'b1);
    store(2'd0, 32'h600, 32'h000000AB, 1, 1'b1);
    store(2'd0, 32'h601, 32'h000000CD, 0, 1'b1);
    store(2'd1, 32'h203, 32'h0000BEEF, 0, 1'b1);
    store(2'd2, 32'h700, 32'hCAFEF00D, WAIT_MAX - 1, 1'b1);
    store(2'd2, 32'h704, 32'h0BADF00D, WAIT_MAX, 1'b1);

    // reset while the request is outstanding: store is dropped silently
    store(2'd2, 32'h900, 32'h12345678, 99, 1'b0);
    check("req_before_rst", 80'(mem_req), 80'(1'b1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", 80'({mem_req, busy, mem_be, done, err, st_ready}),
          80'({1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1}));
    last_code = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    store(2'd1, 32'h802, 32'h00001234, 2, 1'b1);

    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      store(sz, $urandom, $urandom, $urandom_range(0, WAIT_MAX + 1), 1'b1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
